// File: rtl/gray_seq_monitor.sv
// Gray-code stream consumer: decodes each Valid sample and checks single-step increments.
// Optional GRAY_SEQ_RESYNC_EN lets the monitor re-baseline after an error instead of stopping.
module gray_seq_monitor #(
  parameter int WIDTH      = 3,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Valid,
  input  logic [WIDTH-1:0]      GrayIn,
  output logic [WIDTH-1:0]      Binary,
  output logic                  Locked,
  output logic                  Wrapped,
  output logic [WRAP_CNT_W-1:0] WrapCount,
  output logic                  Error
);

  // state    | meaning
  // ST_IDLE  | waiting for the first sample, which becomes the baseline
  // ST_TRACK | checking each sample against the last accepted value
  // ST_ERR   | illegal step seen; terminal or re-baselining (GRAY_SEQ_RESYNC_EN)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  localparam logic [WIDTH-1:0]      BIN_MAX = '1;
  localparam logic [WRAP_CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [1:0]            state_q,    state_d;
  logic [WIDTH-1:0]      binary_q,   binary_d;
  logic                  wrapped_q,  wrapped_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                  error_q,    error_d;

  logic [WIDTH-1:0] dec;
  logic [WIDTH:0]   bin_inc;
  logic             is_repeat;
  logic             is_step;
  logic             is_wrap;

  assign dec = gray2bin(GrayIn);

  // Increment is one bit wider so max -> 0 is never mistaken for a plain step.
  assign bin_inc   = {1'b0, binary_q} + {{WIDTH{1'b0}}, 1'b1};
  assign is_repeat = (dec == binary_q);
  assign is_step   = (binary_q != BIN_MAX) && ({1'b0, dec} == bin_inc);
  assign is_wrap   = (binary_q == BIN_MAX) && (dec == '0);

  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    wrapped_d  = wrapped_q;
    wrap_cnt_d = wrap_cnt_q;
    error_d    = error_q;

    if (Valid) begin
      case (state_q)
        ST_IDLE: begin
          binary_d = dec;
          state_d  = ST_TRACK;
        end
        ST_TRACK: begin
          if (is_repeat) begin
            binary_d = binary_q;
          end else if (is_step) begin
            binary_d = dec;
          end else if (is_wrap) begin
            binary_d  = '0;
            wrapped_d = 1'b1;
            if (wrap_cnt_q != CNT_MAX) begin
              wrap_cnt_d = wrap_cnt_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
`ifdef GRAY_SEQ_RESYNC_EN
          binary_d = dec;
          state_d  = ST_TRACK;
`else
          state_d  = ST_ERR;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      binary_q   <= '0;
      wrapped_q  <= 1'b0;
      wrap_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      wrapped_q  <= wrapped_d;
      wrap_cnt_q <= wrap_cnt_d;
      error_q    <= error_d;
    end
  end

  assign Binary    = binary_q;
  assign Locked    = (state_q == ST_TRACK);
  assign Wrapped   = wrapped_q;
  assign WrapCount = wrap_cnt_q;
  assign Error     = error_q;

endmodule
